// File: rtl/stack_ptr_unit_if.sv
// stack_ptr_unit_if
//   Request/response bundle between the control unit and the stack pointer unit.
//   master : control side, drives push/pop/sp_we/sp_wdata/fault_clr and observes status.
//   slave  : stack_ptr_unit side, drives push_ok/pop_ok/stack_addr/sp/depth and the flags.
interface stack_ptr_unit_if;
   logic        push;
   logic        pop;
   logic        sp_we;
   logic [15:0] sp_wdata;
   logic        fault_clr;
   logic [15:0] sp;
   logic [15:0] stack_addr;
   logic        push_ok;
   logic        pop_ok;
   logic [9:0]  depth;
   logic        overflow;
   logic        underflow;
   logic        fault;

   modport master (
      output push, pop, sp_we, sp_wdata, fault_clr,
      input  sp, stack_addr, push_ok, pop_ok, depth, overflow, underflow, fault
   );

   modport slave (
      input  push, pop, sp_we, sp_wdata, fault_clr,
      output sp, stack_addr, push_ok, pop_ok, depth, overflow, underflow, fault
   );
endinterface

// File: rtl/stack_ptr_unit.sv
// stack_ptr_unit
//   Owns the data-memory stack pointer. Qualifies push/pop requests against the stack
//   bounds, presents the per-cycle stack address to DM with zero latency, tracks depth and
//   latches overflow/underflow faults until fault_clr.
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : stack_ptr_unit_if.slave
//          in : push, pop, sp_we, sp_wdata[15:0], fault_clr
//          out: sp[15:0], stack_addr[15:0], push_ok, pop_ok, depth[9:0],
//               overflow, underflow, fault
module stack_ptr_unit #(
   parameter int          AW           = 9,
   parameter logic [AW-1:0] STACK_TOP    = 9'h1FF,
   parameter logic [AW-1:0] STACK_BOTTOM = 9'h100
) (
   input  logic              clk,
   input  logic              rst,
   stack_ptr_unit_if.slave   bus
);

   localparam logic [9:0]  DEPTH = 10'(int'(STACK_TOP) - int'(STACK_BOTTOM) + 1);
   localparam logic [15:0] TOP16 = 16'(STACK_TOP);
   // Lowest legal software SP: one below the bottom word, i.e. a completely full stack.
   localparam logic [15:0] LO16  = 16'(STACK_BOTTOM) - 16'd1;

   typedef enum logic {NORMAL, FAULT} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   sp_q, sp_d;
   logic [9:0]      depth_q, depth_d;
   logic            overflow_q, overflow_d;
   logic            underflow_q, underflow_d;

   logic            full, empty, is_normal;
   logic            push_ok, pop_ok;
   logic [AW-1:0]   addr;

   // Request qualification; gated by rst so DM sees no strobe while in reset.
   always_comb begin
      full      = (depth_q == DEPTH);
      empty     = (depth_q == 10'd0);
      is_normal = (state_q == NORMAL);
      push_ok   = ~rst & is_normal & bus.push & ~bus.pop & ~bus.sp_we & ~bus.fault_clr & ~full;
      pop_ok    = ~rst & is_normal & bus.pop & ~bus.push & ~bus.sp_we & ~bus.fault_clr & ~empty;
      // Stack grows down: push writes at sp, pop reads the word just above it.
      addr      = pop_ok ? sp_q + AW'(1) : sp_q;
   end

   // Next-state / datapath update, priority ordered.
   always_comb begin
      state_d     = state_q;
      sp_d        = sp_q;
      depth_d     = depth_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.fault_clr) begin
         state_d     = NORMAL;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else if (is_normal) begin
         if (bus.sp_we) begin
            if (bus.sp_wdata < LO16) begin
               overflow_d = 1'b1;
               state_d    = FAULT;
            end else if (bus.sp_wdata > TOP16) begin
               underflow_d = 1'b1;
               state_d     = FAULT;
            end else begin
               sp_d    = bus.sp_wdata[AW-1:0];
               depth_d = 10'(TOP16 - bus.sp_wdata);
            end
         end else if (push_ok) begin
            sp_d    = sp_q - AW'(1);
            depth_d = depth_q + 10'd1;
         end else if (pop_ok) begin
            sp_d    = sp_q + AW'(1);
            depth_d = depth_q - 10'd1;
         end else if (bus.push && !bus.pop && full) begin
            overflow_d = 1'b1;
            state_d    = FAULT;
         end else if (bus.pop && !bus.push && empty) begin
            underflow_d = 1'b1;
            state_d     = FAULT;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= NORMAL;
         sp_q        <= STACK_TOP;
         depth_q     <= 10'd0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sp_q        <= sp_d;
         depth_q     <= depth_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.push_ok    = push_ok;
   assign bus.pop_ok     = pop_ok;
   assign bus.stack_addr = 16'(addr);
   assign bus.sp         = 16'(sp_q);
   assign bus.depth      = depth_q;
   assign bus.overflow   = overflow_q;
   assign bus.underflow  = underflow_q;
   assign bus.fault      = (state_q == FAULT);

endmodule

// File: tb/tb_stack_ptr_unit.sv
module tb_stack_ptr_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stack_ptr_unit_if ifa();
   stack_ptr_unit_if ifb();

   // dut_a: full-size stack; dut_b: 4-word stack for the overflow boundary
   stack_ptr_unit #(.AW(9), .STACK_TOP(9'h1FF), .STACK_BOTTOM(9'h100)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa));
   stack_ptr_unit #(.AW(9), .STACK_TOP(9'h1FF), .STACK_BOTTOM(9'h1FC)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb));

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;
   exp_t sb_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   string cur_t = "";

   int m_sp[2], m_depth[2], m_ovf[2], m_udf[2], m_flt[2];
   int m_top[2] = '{'h1FF, 'h1FF};
   int m_bot[2] = '{'h100, 'h1FC};

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %0h want %0h", cur_t, tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs(int sel, string tag);
      logic [31:0] r;
      r = 32'hDEAD_BEEF;
      case (tag)
         "push_ok":    r = {31'b0, sel ? ifb.push_ok   : ifa.push_ok};
         "pop_ok":     r = {31'b0, sel ? ifb.pop_ok    : ifa.pop_ok};
         "stack_addr": r = {16'b0, sel ? ifb.stack_addr : ifa.stack_addr};
         "sp":         r = {16'b0, sel ? ifb.sp        : ifa.sp};
         "depth":      r = {22'b0, sel ? ifb.depth     : ifa.depth};
         "overflow":   r = {31'b0, sel ? ifb.overflow  : ifa.overflow};
         "underflow":  r = {31'b0, sel ? ifb.underflow : ifa.underflow};
         "fault":      r = {31'b0, sel ? ifb.fault     : ifa.fault};
         default:      r = 32'hDEAD_BEEF;
      endcase
      return r;
   endfunction

   task automatic expect_v(string tag, int v);
      exp_t e;
      e.tag = tag;
      e.v   = 32'(v);
      sb_q.push_back(e);
   endtask

   task automatic expect_regs(int d);
      expect_v("sp", m_sp[d]);
      expect_v("depth", m_depth[d]);
      expect_v("overflow", m_ovf[d]);
      expect_v("underflow", m_udf[d]);
      expect_v("fault", m_flt[d]);
   endtask

   task automatic drain(int sel);
      exp_t e;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk(e.tag, obs(sel, e.tag), e.v);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_sp[d] = m_top[d]; m_depth[d] = 0;
         m_ovf[d] = 0; m_udf[d] = 0; m_flt[d] = 0;
      end
   endtask

   task automatic drive(int sel, bit pu, bit po, bit we, int wd, bit clr);
      ifa.push = 0; ifa.pop = 0; ifa.sp_we = 0; ifa.sp_wdata = '0; ifa.fault_clr = 0;
      ifb.push = 0; ifb.pop = 0; ifb.sp_we = 0; ifb.sp_wdata = '0; ifb.fault_clr = 0;
      if (sel == 0) begin
         ifa.push = pu; ifa.pop = po; ifa.sp_we = we; ifa.sp_wdata = 16'(wd); ifa.fault_clr = clr;
      end else begin
         ifb.push = pu; ifb.pop = po; ifb.sp_we = we; ifb.sp_wdata = 16'(wd); ifb.fault_clr = clr;
      end
   endtask

   // One clock of stimulus: strobes/address checked mid-cycle, registers after the edge.
   task automatic step(int sel, bit pu, bit po, bit we, int wd, bit clr);
      bit full, empty, nrm, pok, qok;
      int dmax;
      drive(sel, pu, po, we, wd, clr);
      dmax  = m_top[sel] - m_bot[sel] + 1;
      full  = (m_depth[sel] == dmax);
      empty = (m_depth[sel] == 0);
      nrm   = (m_flt[sel] == 0);
      pok   = nrm && pu && !po && !we && !clr && !full;
      qok   = nrm && po && !pu && !we && !clr && !empty;
      expect_v("push_ok", int'(pok));
      expect_v("pop_ok", int'(qok));
      expect_v("stack_addr", qok ? m_sp[sel] + 1 : m_sp[sel]);
      @(negedge clk);
      drain(sel);
      if (clr) begin
         m_flt[sel] = 0; m_ovf[sel] = 0; m_udf[sel] = 0;
      end else if (nrm) begin
         if (we) begin
            if (wd < m_bot[sel] - 1) begin
               m_ovf[sel] = 1; m_flt[sel] = 1;
            end else if (wd > m_top[sel]) begin
               m_udf[sel] = 1; m_flt[sel] = 1;
            end else begin
               m_sp[sel] = wd; m_depth[sel] = m_top[sel] - wd;
            end
         end else if (pok) begin
            m_sp[sel]--; m_depth[sel]++;
         end else if (qok) begin
            m_sp[sel]++; m_depth[sel]--;
         end else if (pu && !po && full) begin
            m_ovf[sel] = 1; m_flt[sel] = 1;
         end else if (po && !pu && empty) begin
            m_udf[sel] = 1; m_flt[sel] = 1;
         end
      end
      expect_regs(sel);
      @(posedge clk);
      #1;
      drain(sel);
   endtask

   initial begin
      int r;
      // T1: reset, with a push held to show strobes are blocked in reset
      cur_t = "T1";
      rst = 1'b1;
      drive(0, 1, 0, 0, 0, 0);
      #2;
      model_reset();
      expect_v("push_ok", 0);
      expect_regs(0);
      drain(0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      expect_regs(0);
      drain(0);

      cur_t = "T2";
      repeat (3) step(0, 1, 0, 0, 0, 0);
      repeat (3) step(0, 0, 1, 0, 0, 0);

      cur_t = "T3";
      step(0, 0, 1, 0, 0, 0);            // pop on empty -> underflow
      step(0, 1, 0, 0, 0, 0);            // ignored while faulted
      step(0, 0, 0, 1, 'h180, 0);        // sp_we ignored while faulted
      step(0, 1, 0, 0, 0, 1);            // fault_clr wins over push
      step(0, 1, 0, 0, 0, 0);

      cur_t = "T4";
      repeat (4) step(1, 1, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);            // 5th push -> overflow
      step(1, 0, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0, 0);

      cur_t = "T5";
      step(0, 1, 0, 0, 0, 0);            // depth now 2
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);

      cur_t = "T6";
      step(0, 0, 0, 1, 'h180, 0);
      step(0, 0, 0, 1, 'h050, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 'h200, 0);        // above top -> underflow
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 1, 'h0FF, 0);        // exactly full, depth 256
      step(0, 1, 0, 0, 0, 0);            // push on full -> overflow
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 'h1FF, 0);        // back to empty

      cur_t = "RND";
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1, 2, 3: step(0, 1, 0, 0, 0, 0);
            4, 5, 6:    step(0, 0, 1, 0, 0, 0);
            7:          step(0, 1, 1, 0, 0, 0);
            8:          step(0, 0, 0, 0, 0, 1);
            default:    step(0, 0, 0, 1, int'($urandom_range('h0F0, 'h210)), 0);
         endcase
      end

      // Mid-cycle reset: async, no edge needed, and pending push is dropped
      cur_t = "RST";
      step(0, 0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      expect_v("push_ok", 0);
      expect_regs(0);
      drain(0);
      drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      expect_regs(0);
      drain(0);
      step(0, 1, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
